// File: rtl/key_event_detector_pkg.sv
// ============================================================================
// Module      : key_event_detector_pkg
// Description : Shared FSM state encodings and 50 MHz timing constants for the
//               key event detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_event_detector_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Cycle counts at the 50 MHz system clock
  localparam int unsigned CYC_1S    = 50_000_000;
  localparam int unsigned CYC_200MS = 10_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_detector.sv
// ============================================================================
// Module      : key_event_detector
// Description : Turns a debounced key level into press / release / long-press /
//               auto-repeat pulses and keeps a wrapping press counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_detector
  import key_event_detector_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned LONG_CYCLES   = CYC_1S,
  parameter int unsigned REPEAT_CYCLES = CYC_200MS,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_in,
  input  logic             cnt_clr,
  output logic             press_pulse,
  output logic             rel_pulse,
  output logic             long_pulse,
  output logic             rpt_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned TIMER_W = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

  logic               pressed;
  logic               press_edge;

  logic               key_q;
  logic [1:0]         state_q,  state_d;
  logic [TIMER_W-1:0] timer_q,  timer_d;
  logic               press_q,  press_d;
  logic               rel_q,    rel_d;
  logic               long_q,   long_d;
  logic               rpt_q,    rpt_d;
  logic               held_q,   held_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  assign pressed    = (ACTIVE_LOW != 0) ? ~key_in : key_in;
  assign press_edge = pressed & ~key_q;

  // Timer and FSM; a release always beats a coincident timer threshold.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_edge) begin
          state_d = ST_HELD;
          timer_d = '0;
          press_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d = ST_IDLE;
          timer_d = '0;
          rel_d   = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          state_d = ST_REPEAT;
          timer_d = '0;
          long_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!pressed) begin
          state_d = ST_IDLE;
          timer_d = '0;
          rel_d   = 1'b1;
        end else if (timer_q == REPEAT_LAST) begin
          timer_d = '0;
          rpt_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    held_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= 1'b0;
      state_q <= ST_IDLE;
      timer_q <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      key_q   <= pressed;
      state_q <= state_d;
      timer_q <= timer_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
    end
  end

  // A clear coincident with a press counts that press.
  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = press_d ? CNT_W'(1) : '0;
    end else if (press_d) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign press_pulse = press_q;
  assign rel_pulse   = rel_q;
  assign long_pulse  = long_q;
  assign rpt_pulse   = rpt_q;
  assign held        = held_q;
  assign press_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event_detector.sv
// ============================================================================
// Module      : tb_key_event_detector
// Description : Directed and randomised self-checking bench for key_event_detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event_detector;

  localparam int unsigned LONG   = 10;
  localparam int unsigned REPEAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       cnt_clr;
  logic       press_pulse, rel_pulse, long_pulse, rpt_pulse, held;
  logic [1:0] press_count;

  int n_checks = 0;
  int n_errors = 0;

  key_event_detector #(
    .ACTIVE_LOW    (1),
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REPEAT),
    .CNT_W         (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .cnt_clr     (cnt_clr),
    .press_pulse (press_pulse),
    .rel_pulse   (rel_pulse),
    .long_pulse  (long_pulse),
    .rpt_pulse   (rpt_pulse),
    .held        (held),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  // Reference model: counts edges since the press edge instead of a wrapping timer.
  logic       m_prev, m_held, m_press, m_rel, m_long, m_rpt;
  int         m_hold;
  logic [1:0] m_count;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 0; m_held = 0; m_hold = 0; m_count = 0;
      m_press = 0; m_rel = 0; m_long = 0; m_rpt = 0;
    end else begin
      m_press = 0; m_rel = 0; m_long = 0; m_rpt = 0;
      if (!m_held) begin
        if (!key_in && !m_prev) begin
          m_held = 1; m_hold = 0; m_press = 1;
        end
      end else if (key_in) begin
        m_held = 0; m_rel = 1;
      end else begin
        m_hold++;
        if (m_hold == LONG) m_long = 1;
        else if (m_hold > LONG && ((m_hold - LONG) % REPEAT) == 0) m_rpt = 1;
      end
      if (cnt_clr) m_count = m_press ? 2'd1 : 2'd0;
      else if (m_press) m_count = m_count + 2'd1;
      m_prev = !key_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {press, rel, long, rpt, held, count}
  function automatic logic [6:0] outs();
    return {press_pulse, rel_pulse, long_pulse, rpt_pulse, held, press_count};
  endfunction

  initial begin
    int   len;
    logic last_press;

    rst = 1'b1; key_in = 1'b1; cnt_clr = 1'b0;
    tick(2);
    check("reset_outs", outs(), 7'b0000000);
    rst = 1'b0;
    tick(2);
    check("idle_outs", outs(), 7'b0000000);

    // 1: short press
    key_in = 1'b0;
    tick(1);
    check("t1_press", outs(), 7'b1000101);
    tick(1);
    check("t1_press_gone", outs(), 7'b0000101);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t1_hold", outs(), 7'b0000101);
    end
    key_in = 1'b1;
    tick(1);
    check("t1_release", outs(), 7'b0100001);
    tick(1);
    check("t1_idle", outs(), 7'b0000001);

    // 2: long press with auto-repeat
    key_in = 1'b0;
    tick(1);
    check("t2_press", outs(), 7'b1000110);
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      check("t2_long_rpt", {long_pulse, rpt_pulse, held},
            {(i == 10), (i == 14 || i == 18 || i == 22), 1'b1});
    end
    key_in = 1'b1;
    tick(1);
    check("t2_release", outs(), 7'b0100010);
    tick(1);

    // 3: release on the long threshold edge
    key_in = 1'b0;
    tick(1);
    check("t3_press", outs(), 7'b1000111);
    tick(8);
    check("t3_hold9", outs(), 7'b0000111);
    tick(1);
    key_in = 1'b1;
    tick(1);
    check("t3_rel_wins", outs(), 7'b0100011);
    tick(1);
    check("t3_idle", outs(), 7'b0000011);

    // 4: clear then wrap
    cnt_clr = 1'b1;
    tick(1);
    check("t4_clr", press_count, 2'd0);
    cnt_clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      key_in = 1'b0;
      tick(1);
      check("t4_count", {press_pulse, press_count}, {1'b1, 2'(i % 4)});
      key_in = 1'b1;
      tick(1);
      check("t4_rel", rel_pulse, 1'b1);
    end
    key_in = 1'b0; cnt_clr = 1'b1;
    tick(1);
    check("t4_clr_press", {press_pulse, press_count}, 3'b101);
    cnt_clr = 1'b0;

    // 5: asynchronous reset while in REPEAT
    tick(12);
    check("t5_pre_rst", outs(), 7'b0000101);
    #2 rst = 1'b1;
    #1 check("t5_async_rst", outs(), 7'b0000000);
    tick(1);
    check("t5_no_rel", outs(), 7'b0000000);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("t5_repress", outs(), 7'b1000101);
    key_in = 1'b1;
    tick(1);
    check("t5_release", outs(), 7'b0100001);

    // 6: random levels against the model
    last_press = 1'b0;
    for (int lv = 0; lv < 12; lv++) begin
      key_in = ~key_in;
      len = 20 + int'($urandom_range(0, 30));
      for (int c = 0; c < len; c++) begin
        cnt_clr = ($urandom_range(0, 15) == 0);
        tick(1);
        check("rnd_outs", outs(), {m_press, m_rel, m_long, m_rpt, m_held, m_count});
        check("rnd_onehot", ($countones({press_pulse, rel_pulse, long_pulse, rpt_pulse}) <= 1), 1);
        if (press_pulse) begin
          check("rnd_alt_press", last_press, 1'b0);
          last_press = 1'b1;
        end
        if (rel_pulse) begin
          check("rnd_alt_rel", last_press, 1'b1);
          last_press = 1'b0;
        end
      end
    end
    cnt_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
